// File: rtl/mt_pc_unit_pkg.sv
// Shared fetch definitions for the multi-context PC unit and IF/ID.
// Thread-ID width derivation, reset defaults and the fetch bundle.
package mt_pc_unit_pkg;

   localparam int unsigned FETCH_ADDR_W = 9;
   localparam int unsigned FETCH_TID_W  = 2;
   localparam int unsigned RESET_PC_DEF = 0;

   typedef struct packed {
      logic                    valid;
      logic [FETCH_TID_W-1:0]  tid;
      logic [FETCH_ADDR_W-1:0] pc;
   } fetch_t;

   // ceil(log2(n)), never below 1 so a single thread still has a tid bit
   function automatic int unsigned tid_w_of(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/mt_pc_unit_rr.sv
// Rotating priority encoder: first set mask bit at or after ptr.
// Shared with the thread scheduler further down the pipeline.
module rr_pick_first #(
   parameter int unsigned N = 4,
   parameter int unsigned W = 2
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] sel,
   output logic         any
);

   int idx;

   always_comb begin
      sel = '0;
      any = 1'b0;
      idx = 0;
      for (int i = 0; i < int'(N); i++) begin
         idx = int'(ptr) + i;
         if (idx >= int'(N)) idx = idx - int'(N);
         if (!any && mask[idx]) begin
            any = 1'b1;
            sel = W'(idx);
         end
      end
   end

endmodule

// File: rtl/mt_pc_unit.sv
// Per-thread program counters with round-robin fetch issue,
// stall hold and branch redirect; feeds IF/ID.
module mt_pc_unit
   import mt_pc_unit_pkg::*;
#(
   parameter int unsigned ADDR_W      = 9,
   parameter int unsigned NUM_THREADS = 4,
   parameter int unsigned TID_W       = tid_w_of(NUM_THREADS),
   parameter int unsigned STEP        = 1,
   parameter int unsigned RESET_PC    = RESET_PC_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic [NUM_THREADS-1:0] thread_en,
   input  logic                   br_valid,
   input  logic [TID_W-1:0]       br_tid,
   input  logic [ADDR_W-1:0]      br_target,
   output logic                   fetch_valid,
   output logic [ADDR_W-1:0]      fetch_pc,
   output logic [TID_W-1:0]       fetch_tid
);

   logic [ADDR_W-1:0] pc_q [NUM_THREADS];
   logic [TID_W-1:0]  rr_ptr;
   logic [TID_W-1:0]  sel;
   logic [TID_W-1:0]  rr_next;
   logic              any;
   logic              issue;

   rr_pick_first #(
      .N (NUM_THREADS),
      .W (TID_W)
   ) u_pick (
      .mask (thread_en),
      .ptr  (rr_ptr),
      .sel  (sel),
      .any  (any)
   );

   assign issue = !stall && any;

   always_comb begin
      rr_next = sel + TID_W'(1);
      if (int'(sel) + 1 >= int'(NUM_THREADS)) rr_next = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int t = 0; t < int'(NUM_THREADS); t++)
            pc_q[t] <= ADDR_W'(RESET_PC);
         rr_ptr      <= '0;
         fetch_valid <= 1'b0;
         fetch_pc    <= '0;
         fetch_tid   <= '0;
      end else begin
         if (!stall) begin
            fetch_valid <= any;
            if (any) begin
               fetch_pc  <= pc_q[sel];
               fetch_tid <= sel;
               rr_ptr    <= rr_next;
            end
         end
         // redirect beats the post-issue increment; issued fetch is stale
         for (int t = 0; t < int'(NUM_THREADS); t++) begin
            if (br_valid && int'(br_tid) == t)
               pc_q[t] <= br_target;
            else if (issue && int'(sel) == t)
               pc_q[t] <= pc_q[t] + ADDR_W'(STEP);
         end
      end
   end

endmodule

// File: tb/tb_mt_pc_unit.sv
// Directed vector table plus randomized run against a reference model.
module tb_mt_pc_unit;

   typedef struct {
      bit       rst;
      bit       stl;
      bit [3:0] en;
      bit       bv;
      bit [1:0] bt;
      bit [8:0] btg;
      bit       ev;
      bit [1:0] et;
      bit [8:0] ep;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       stall;
   logic [3:0] thread_en;
   logic       br_valid;
   logic [1:0] br_tid;
   logic [8:0] br_target;
   logic       fetch_valid;
   logic [8:0] fetch_pc;
   logic [1:0] fetch_tid;

   int total = 0;
   int bad   = 0;

   vec_t vq[$];

   mt_pc_unit dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .thread_en   (thread_en),
      .br_valid    (br_valid),
      .br_tid      (br_tid),
      .br_target   (br_target),
      .fetch_valid (fetch_valid),
      .fetch_pc    (fetch_pc),
      .fetch_tid   (fetch_tid)
   );

   always #5 clk = ~clk;

   function automatic void add(
      input bit rst, input bit stl, input bit [3:0] en,
      input bit bv, input bit [1:0] bt, input bit [8:0] btg,
      input bit ev, input bit [1:0] et, input bit [8:0] ep);
      vec_t v;
      v.rst = rst; v.stl = stl; v.en = en;
      v.bv = bv; v.bt = bt; v.btg = btg;
      v.ev = ev; v.et = et; v.ep = ep;
      vq.push_back(v);
   endfunction

   task automatic drive(
      input bit rst, input bit stl, input bit [3:0] en,
      input bit bv, input bit [1:0] bt, input bit [8:0] btg);
      reset = rst; stall = stl; thread_en = en;
      br_valid = bv; br_tid = bt; br_target = btg;
   endtask

   task automatic check(
      input string nm, input int idx,
      input bit ev, input bit [1:0] et, input bit [8:0] ep);
      total++;
      if (fetch_valid !== ev || fetch_tid !== et || fetch_pc !== ep) begin
         bad++;
         $display("FAIL %s[%0d]: got v=%b tid=%0d pc=%h want v=%b tid=%0d pc=%h",
                  nm, idx, fetch_valid, fetch_tid, fetch_pc, ev, et, ep);
      end
   endtask

   int       mpc [4];
   int       mptr;
   bit       mv;
   int       mt;
   int       mp;

   initial begin
      drive(1, 0, 4'h0, 0, 0, 0);

      // round-robin across all four threads from reset
      add(1, 0, 4'hF, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 22; i++)
         add(0, 0, 4'hF, 0, 0, 0, 1, 2'(i % 4), 9'(i / 4));
      // stall after (1,5): hold three cycles, resume at (2,5)
      for (int i = 0; i < 3; i++)
         add(0, 1, 4'hF, 0, 0, 0, 1, 1, 5);
      add(0, 0, 4'hF, 0, 0, 0, 1, 2, 5);
      add(0, 0, 4'hF, 0, 0, 0, 1, 3, 5);
      add(0, 0, 4'hF, 0, 0, 0, 1, 0, 6);
      // reset while stalled with nonzero PCs
      add(1, 1, 4'hF, 0, 0, 0, 0, 0, 0);
      add(0, 0, 4'hF, 0, 0, 0, 1, 0, 0);
      // sparse mask, then no thread enabled
      add(1, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 4'h5, 0, 0, 0, 1, 0, 0);
      add(0, 0, 4'h5, 0, 0, 0, 1, 2, 0);
      add(0, 0, 4'h5, 0, 0, 0, 1, 0, 1);
      add(0, 0, 4'h5, 0, 0, 0, 1, 2, 1);
      add(0, 0, 4'h0, 0, 0, 0, 0, 2, 1);
      add(0, 0, 4'h0, 0, 0, 0, 0, 2, 1);
      // branch into the issuing thread: stale fetch, then target
      add(1, 0, 4'h0, 0, 0, 0, 0, 0, 0);
      add(0, 0, 4'h0, 1, 2, 9'h003, 0, 0, 0);
      add(0, 0, 4'h4, 1, 2, 9'h040, 1, 2, 9'h003);
      add(0, 0, 4'h4, 0, 0, 0, 1, 2, 9'h040);
      add(0, 0, 4'h4, 0, 0, 0, 1, 2, 9'h041);
      // PC wrap at the top of the address space
      add(0, 0, 4'h0, 1, 0, 9'h1FF, 0, 2, 9'h041);
      add(0, 0, 4'h1, 0, 0, 0, 1, 0, 9'h1FF);
      add(0, 0, 4'h1, 0, 0, 0, 1, 0, 9'h000);
      add(0, 0, 4'h1, 0, 0, 0, 1, 0, 9'h001);
      // branch accepted while stalled
      add(0, 1, 4'h1, 1, 0, 9'h010, 1, 0, 9'h001);
      add(0, 0, 4'h1, 0, 0, 0, 1, 0, 9'h010);
      add(0, 0, 4'h1, 0, 0, 0, 1, 0, 9'h011);

      foreach (vq[i]) begin
         drive(vq[i].rst, vq[i].stl, vq[i].en,
               vq[i].bv, vq[i].bt, vq[i].btg);
         @(posedge clk);
         #1;
         check("vec", i, vq[i].ev, vq[i].et, vq[i].ep);
      end

      // randomized run against the reference model
      drive(1, 0, 4'h0, 0, 0, 0);
      @(posedge clk);
      #1;
      for (int t = 0; t < 4; t++) mpc[t] = 0;
      mptr = 0; mv = 0; mt = 0; mp = 0;
      check("rnd_reset", 0, 0, 0, 0);

      for (int c = 0; c < 600; c++) begin
         bit       rst, stl, bv;
         bit [3:0] en;
         bit [1:0] bt;
         bit [8:0] btg;
         int       sel;
         rst = ($urandom_range(0, 63) == 0);
         stl = ($urandom_range(0, 4) == 0);
         bv  = ($urandom_range(0, 4) == 0);
         en  = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
         bt  = 2'($urandom);
         btg = ($urandom_range(0, 3) == 0) ? 9'h1FE + 9'($urandom_range(0, 1))
                                            : 9'($urandom);
         drive(rst, stl, en, bv, bt, btg);

         if (rst) begin
            for (int t = 0; t < 4; t++) mpc[t] = 0;
            mptr = 0; mv = 0; mt = 0; mp = 0;
         end else begin
            sel = -1;
            for (int k = 0; k < 4; k++)
               if (sel < 0 && en[(mptr + k) % 4]) sel = (mptr + k) % 4;
            if (!stl) begin
               mv = (sel >= 0);
               if (sel >= 0) begin
                  mt = sel;
                  mp = mpc[sel];
                  mptr = (sel + 1) % 4;
                  mpc[sel] = (mpc[sel] + 1) % 512;
               end
            end
            if (bv) mpc[bt] = btg;
         end

         @(posedge clk);
         #1;
         check("rnd", c, mv, 2'(mt), 9'(mp));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mt_pc_unit.md
Name: mt_pc_unit

Overview:
Parametrised, multi-context successor to the single-thread PC incrementer. Holds one program counter per hardware thread and issues one fetch address per cycle, chosen round-robin among enabled threads. Supports pipeline stall and per-thread branch redirect. Sits at the head of the fetch stage and drives instruction-memory address plus thread ID into IF/ID.

Parameters:
ADDR_W, 9, PC / instruction-address width in bits
NUM_THREADS, 4, number of thread contexts (1..16)
TID_W, 2, thread-ID width, at least ceil(log2(NUM_THREADS)), minimum 1
STEP, 1, increment applied to a PC after it issues
RESET_PC, 0, value loaded into every PC on reset

Ports:
clk  in  1  single clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
stall  in  1  hold issue, PCs (except branch writes) and round-robin pointer
thread_en  in  NUM_THREADS  per-thread enable mask; bit t=1 makes thread t eligible
br_valid  in  1  branch/jump redirect strobe
br_tid  in  TID_W  thread being redirected
br_target  in  ADDR_W  new PC for br_tid
fetch_valid  out  1  registered; fetch_pc/fetch_tid are meaningful
fetch_pc  out  ADDR_W  registered fetch address
fetch_tid  out  TID_W  registered thread ID of fetch_pc

Behaviour:
- State: pc[0..NUM_THREADS-1] (ADDR_W bits each); rr_ptr (TID_W bits); output registers.
- Reset (synchronous, priority over everything): every pc = RESET_PC, rr_ptr = 0, fetch_valid = 0, fetch_pc = 0, fetch_tid = 0.
- Selection (combinational): sel = first t with thread_en[t]=1, scanning rr_ptr, rr_ptr+1, ... modulo NUM_THREADS. rr_ptr itself is included.
- Issue cycle (stall=0, at least one thread enabled):
  - fetch_valid <= 1, fetch_tid <= sel, fetch_pc <= pc[sel].
  - pc[sel] <= pc[sel] + STEP, truncated to ADDR_W. Wrap: 2^ADDR_W-1 + 1 gives 0.
  - rr_ptr <= (sel+1) mod NUM_THREADS.
  - Latency: one cycle from PC value to fetch_pc.
- No enabled thread (stall=0): fetch_valid <= 0; fetch_pc and fetch_tid hold; PCs and rr_ptr hold.
- Stall=1:
  - fetch_valid, fetch_pc, fetch_tid, rr_ptr and all PC increments hold.
  - Downstream re-samples the same fetch.
- Branch (br_valid=1, br_tid < NUM_THREADS): pc[br_tid] <= br_target, honoured even while stalled.
  - If br_tid == sel in an issue cycle, the branch write wins over the increment.
  - The fetch issued that cycle still carries the old pc[sel]; there is no bypass. Downstream squashes it.
- br_tid >= NUM_THREADS: branch ignored.
- thread_en changes take effect in the same cycle's selection. A disabled thread's PC is frozen but still accepts branch writes.
- NUM_THREADS=1: rr_ptr is constant 0; the block degenerates to a stallable PC+STEP with branch load.

Decomposition:
- Shared fetch package: TID_W derivation function (clog2), RESET_PC default, and a fetch-bundle typedef {valid, tid, pc} reused by IF/ID.
- One natural sub-module: rr_pick_first (rotating priority encoder: mask + pointer -> sel, any). It is reusable for the thread scheduler elsewhere in the pipeline.

Test Plan:
- Reset, then thread_en=4'b1111 for 8 cycles -> fetch sequence (tid,pc) = (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1); fetch_valid=1 from the first cycle after reset deasserts.
- thread_en=4'b0101 from reset -> tids alternate 0,2,0,2 with pcs 0,0,1,1; set to 4'b0000 -> fetch_valid=0 next cycle and outputs hold.
- stall=1 for 3 cycles mid-stream (last issued (1,5)) -> outputs stay (1,5) for 3 cycles; with stall released the next fetch is (2,5), with no skipped or duplicated PCs.
- br_valid with br_tid=2, br_target=9'h040 in the same cycle thread 2 issues pc 3 -> fetch shows (2,3); thread 2's next fetch shows pc 0x040, not 4.
- Preload pc[0]=9'h1FF via branch, thread_en=4'b0001 -> fetch pcs 0x1FF, 0x000, 0x001 (wrap).
- Assert reset while stalled with nonzero PCs -> next cycle fetch_valid=0 and all PCs at RESET_PC; the first fetch after reset is (0,0).
